cond_unit: RTL and testbench
============================

# cond_unit

Conditional-execution stage for the single-cycle ARM-subset datapath. It sits directly downstream of the instruction decoder. It consumes the decoder's PCS, RegW, MemW and FlagW outputs, the instruction condition field and the ALU flags. It holds the architectural NZCV flag register, evaluates the 4-bit condition against the stored flags, and produces the gated write enables PCSrc, RegWrite and MemWrite that drive the PC mux, register file and data memory.

## Interface
Parameters:
- CNT_W, 32, width of the optional statistics counters (only meaningful with COND_STATS_EN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- InstrValid  input  1  current instruction is real. 0 = bubble or stall.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  from decoder: [1] write N,Z; [0] write C,V.
- PCS  input  1  from decoder: instruction writes the PC.
- RegW  input  1  from decoder: instruction writes the register file.
- MemW  input  1  from decoder: instruction writes memory.
- PCSrc  output  1  PCS gated by condition.
- RegWrite  output  1  RegW gated by condition.
- MemWrite  output  1  MemW gated by condition.
- Flags  output  4  current registered {N,Z,C,V}.
- CondEx  output  1  condition passed, qualified by InstrValid.
- ExecCount  output  CNT_W  instructions executed (COND_STATS_EN only).
- SkipCount  output  CNT_W  valid instructions squashed by condition (COND_STATS_EN only).

## Operation
- CondEx = InstrValid & pass(Cond, Flags). Evaluation always uses the registered Flags, never ALUFlags.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: never (treated as 0; reserved encoding is never executed).
- PCSrc = PCS&CondEx, RegWrite = RegW&CondEx, MemWrite = MemW&CondEx. These outputs are purely combinational.
- Flag update at a rising edge:
  - if CondEx & FlagW[1]: N,Z <= ALUFlags[3:2].
  - if CondEx & FlagW[0]: C,V <= ALUFlags[1:0].
  - The two halves update independently. With FlagW=00, or with CondEx=0, the flags hold.
- Statistics counters (COND_STATS_EN only), per edge with InstrValid=1:
  - CondEx=1 increments ExecCount; CondEx=0 increments SkipCount.
  - Both counters saturate at all-ones and never wrap.
  - InstrValid=0 leaves both counters unchanged.

## Timing
- reset=0 asynchronously forces Flags=4'b0000 and ExecCount=SkipCount=0.
  - With Flags=0 during reset, the combinational outputs follow the current inputs. Downstream logic ignores them during reset.
- Flags written by instruction k are visible to the condition of instruction k+1 (one-cycle latency). There is no same-cycle bypass.
- A flag-setting conditional instruction that fails its condition leaves Flags unchanged.
- Reset asserted mid-operation clears the flags at once. The first edge after release behaves as a normal update.
- The combinational path from Cond/InstrValid/PCS/RegW/MemW to PCSrc/RegWrite/MemWrite contains no register.

## Configuration
- COND_STATS_EN defined: the ExecCount and SkipCount registers and their logic are present.
- COND_STATS_EN undefined: no counter registers are built, and ExecCount and SkipCount are tied to 0. Ports stay present so instantiations are identical in both builds.

## Structure
- Shared package holds:
  - the 4-bit condition-code localparams (COND_EQ … COND_AL, COND_NV);
  - the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, cond_check: purely combinational (Cond, Flags) -> pass. It is reused by any later pipelined variant.
- cond_unit itself owns the flag register, the output gating and the optional counters.

## Test plan
- Reset, then Cond=0000 (EQ), PCS=1, InstrValid=1 -> Flags=0000, CondEx=0, PCSrc=0.
- Cond=1110, FlagW=11, ALUFlags=0100, one edge -> Flags=0100. Next instruction Cond=0000, RegW=1 -> RegWrite=1. Cond=0001 -> RegWrite=0.
- Flags=0100, Cond=0001, FlagW=11, ALUFlags=1011, edge -> Flags stay 0100 and MemWrite=0 for MemW=1.
- FlagW=10 with ALUFlags=1111 from Flags=0010 -> Flags=1110. Then FlagW=01 with ALUFlags=0001 -> Flags=1101.
- Flags=1001 (N=1, V=1): GE/GT pass and LT/LE fail. Cond=1111 always gives CondEx=0. InstrValid=0 with Cond=1110 gives all enables 0 and no flag change.
- COND_STATS_EN, CNT_W=4:
  - 20 valid AL instructions -> ExecCount=15 (saturated).
  - 3 failing instructions -> SkipCount=3.
  - 5 bubbles -> both counters unchanged.
  - Pulse reset -> both counters 0.

Source files
------------

// File: rtl/cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit_pkg
// Description : Condition-code encodings and NZCV bit positions shared by the
//               conditional-execution stage and its checker.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit_if
// Description : Decoder/ALU-side control bundle into the conditional-execution
//               stage and the gated enables/flags coming back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_unit_if #(
   parameter int CNT_W = 32
);
   logic             InstrValid;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic [3:0]       Flags;
   logic             CondEx;
   logic [CNT_W-1:0] ExecCount;
   logic [CNT_W-1:0] SkipCount;

   modport master (
      output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
      input  PCSrc, RegWrite, MemWrite, Flags, CondEx, ExecCount, SkipCount
   );

   modport slave (
      input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
      output PCSrc, RegWrite, MemWrite, Flags, CondEx, ExecCount, SkipCount
   );
endinterface
`default_nettype wire

// File: rtl/cond_unit_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational ARM condition evaluation of a 4-bit condition
//               field against an NZCV flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
   import cond_unit_pkg::*;
(
   input  wire logic [3:0] i_cond,
   input  wire logic [3:0] i_flags,
   output logic            o_pass
);
   logic w_n, w_z, w_c, w_v, w_ge;

   assign w_n  = i_flags[FLAG_N];
   assign w_z  = i_flags[FLAG_Z];
   assign w_c  = i_flags[FLAG_C];
   assign w_v  = i_flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = ~w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = ~w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = ~w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = ~w_v;
         COND_HI: o_pass = w_c & ~w_z;
         COND_LS: o_pass = ~w_c | w_z;
         COND_GE: o_pass = w_ge;
         COND_LT: o_pass = ~w_ge;
         COND_GT: o_pass = ~w_z & w_ge;
         COND_LE: o_pass = w_z | ~w_ge;
         COND_AL: o_pass = 1'b1;
         default: o_pass = 1'b0; // reserved encoding never executes
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : Conditional-execution stage: NZCV register, condition gating
//               of PC/register/memory write enables. Optional saturating
//               exec/skip counters enabled by macro COND_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_unit
   import cond_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  wire logic  clk,
   input  wire logic  reset,
   cond_unit_if.slave bus
);
   logic [3:0] r_flags;
   logic       w_pass;
   logic       w_condex;

   // Evaluation deliberately uses the registered flags: no same-cycle bypass.
   cond_check u_cond_check (
      .i_cond  (bus.Cond),
      .i_flags (r_flags),
      .o_pass  (w_pass)
   );

   assign w_condex     = bus.InstrValid & w_pass;
   assign bus.CondEx   = w_condex;
   assign bus.PCSrc    = bus.PCS  & w_condex;
   assign bus.RegWrite = bus.RegW & w_condex;
   assign bus.MemWrite = bus.MemW & w_condex;
   assign bus.Flags    = r_flags;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= 4'b0000;
      end else begin
         if (w_condex & bus.FlagW[1])
            r_flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
         if (w_condex & bus.FlagW[0])
            r_flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
   end

`ifdef COND_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_one = 1;

   logic [CNT_W-1:0] r_exec_cnt;
   logic [CNT_W-1:0] r_skip_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_exec_cnt <= '0;
         r_skip_cnt <= '0;
      end else if (bus.InstrValid) begin
         if (w_condex) begin
            if (r_exec_cnt != '1)
               r_exec_cnt <= r_exec_cnt + c_cnt_one;
         end else begin
            if (r_skip_cnt != '1)
               r_skip_cnt <= r_skip_cnt + c_cnt_one;
         end
      end
   end

   assign bus.ExecCount = r_exec_cnt;
   assign bus.SkipCount = r_skip_cnt;
`else
   assign bus.ExecCount = {CNT_W{1'b0}};
   assign bus.SkipCount = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_unit
// Description : Directed self-checking bench for cond_unit (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_unit;
   import cond_unit_pkg::*;

   localparam int CNT_W = 4;

`ifdef COND_STATS_EN
   localparam int c_stats = 1;
`else
   localparam int c_stats = 0;
`endif

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   cond_unit_if #(.CNT_W(CNT_W)) bus ();

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic p, input logic r, input logic m);
      bus.InstrValid = v;
      bus.Cond       = c;
      bus.ALUFlags   = af;
      bus.FlagW      = fw;
      bus.PCS        = p;
      bus.RegW       = r;
      bus.MemW       = m;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f, input string tag);
      @(negedge clk);
      drive(1'b1, COND_AL, f, 2'b11, 1'b0, 1'b0, 1'b0);
      step();
      chk(tag, {28'd0, bus.Flags}, {28'd0, f});
      bus.FlagW = 2'b00;
   endtask

   // mask bit c is the expected CondEx for condition code c under current flags
   task automatic sweep(input logic [15:0] mask, input string tag);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         drive(1'b1, 4'(c), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
         #1;
         chk($sformatf("%s_c%0d", tag, c), {31'd0, bus.CondEx}, {31'd0, mask[c]});
      end
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, "_flags"}, {28'd0, bus.Flags}, 32'd0);
      chk({tag, "_exec"}, {28'd0, bus.ExecCount}, 32'd0);
      chk({tag, "_skip"}, {28'd0, bus.SkipCount}, 32'd0);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b0;
      drive(1'b1, COND_EQ, 4'b0100, 2'b00, 1'b1, 1'b0, 1'b0);
      #3;
      chk("rst_flags", {28'd0, bus.Flags}, 32'd0);
      chk("rst_condex", {31'd0, bus.CondEx}, 32'd0);
      chk("rst_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
      chk("rst_exec", {28'd0, bus.ExecCount}, 32'd0);
      chk("rst_skip", {28'd0, bus.SkipCount}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // EQ with ALU Z=1 still fails: flags are registered, not bypassed
      @(negedge clk);
      drive(1'b1, COND_EQ, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0);
      #1;
      chk("nobypass_condex", {31'd0, bus.CondEx}, 32'd0);
      step();
      chk("nobypass_flags", {28'd0, bus.Flags}, 32'd0);

      sweep(16'h56AA, "f0000");

      set_flags(4'b0100, "set_0100");
      @(negedge clk);
      drive(1'b1, COND_EQ, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
      #1;
      chk("eq_regwrite", {31'd0, bus.RegWrite}, 32'd1);
      bus.Cond = COND_NE;
      #1;
      chk("ne_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      sweep(16'h66A9, "f0100");

      // failing flag-setting instruction must not touch the flags
      @(negedge clk);
      drive(1'b1, COND_NE, 4'b1011, 2'b11, 1'b0, 1'b0, 1'b1);
      #1;
      chk("fail_memwrite", {31'd0, bus.MemWrite}, 32'd0);
      step();
      chk("fail_flags_hold", {28'd0, bus.Flags}, 32'h4);

      set_flags(4'b0010, "set_0010");
      sweep(16'h55A6, "f0010");
      @(negedge clk);
      drive(1'b1, COND_AL, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0);
      step();
      chk("half_nz", {28'd0, bus.Flags}, 32'hE);
      @(negedge clk);
      drive(1'b1, COND_AL, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0);
      step();
      chk("half_cv", {28'd0, bus.Flags}, 32'hD);

      set_flags(4'b1001, "set_1001");
      sweep(16'h565A, "f1001");
      set_flags(4'b1000, "set_1000");
      sweep(16'h6A9A, "f1000");

      @(negedge clk);
      drive(1'b0, COND_AL, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1);
      #1;
      chk("bubble_en", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx}, 32'h0);
      step();
      chk("bubble_flags", {28'd0, bus.Flags}, 32'h8);

      @(negedge clk);
      drive(1'b1, COND_AL, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
      #1;
      chk("al_en_all", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx}, 32'hF);
      drive(1'b1, COND_AL, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1);
      #1;
      chk("al_en_mix", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx}, 32'hB);
      drive(1'b1, COND_AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
      #1;
      chk("al_en_reg", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx}, 32'h5);

      // mid-operation reset clears at once; first edge after release updates
      set_flags(4'b1111, "set_1111");
      @(negedge clk);
      drive(1'b1, COND_AL, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk("midrst_flags", {28'd0, bus.Flags}, 32'h0);
      #1;
      reset = 1'b1;
      step();
      chk("postrst_update", {28'd0, bus.Flags}, 32'h5);

      pulse_reset("cnt_rst0");
      @(negedge clk);
      drive(1'b1, COND_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (20) step();
      chk("exec_sat", {28'd0, bus.ExecCount}, (c_stats != 0) ? 32'd15 : 32'd0);
      chk("skip_after_exec", {28'd0, bus.SkipCount}, 32'd0);
      @(negedge clk);
      drive(1'b1, COND_NV, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      chk("skip_3", {28'd0, bus.SkipCount}, (c_stats != 0) ? 32'd3 : 32'd0);
      chk("exec_hold", {28'd0, bus.ExecCount}, (c_stats != 0) ? 32'd15 : 32'd0);
      @(negedge clk);
      drive(1'b0, COND_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (5) step();
      chk("bubble_exec", {28'd0, bus.ExecCount}, (c_stats != 0) ? 32'd15 : 32'd0);
      chk("bubble_skip", {28'd0, bus.SkipCount}, (c_stats != 0) ? 32'd3 : 32'd0);
      pulse_reset("cnt_rst1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
